// File: rtl/vend_coin_feeder_if.sv
// Coin-feeder handshake bundle: payment request in, coin strobes out,
// machine dispense/change responses in, transaction outcome out.
interface vend_coin_feeder_if #(
  parameter int AMT_W = 6
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             i;
  logic             j;
  logic             X;
  logic             Y;
  logic             done;
  logic             dispensed;
  logic             change_seen;
  logic             timeout_err;
  logic [AMT_W-1:0] steps_left;

  modport master (
    input  req_valid, req_amount, X, Y,
    output req_ready, i, j, done, dispensed, change_seen, timeout_err, steps_left
  );

  modport slave (
    output req_valid, req_amount, X, Y,
    input  req_ready, i, j, done, dispensed, change_seen, timeout_err, steps_left
  );
endinterface

// File: rtl/vend_coin_feeder.sv
// Customer-side coin feeder: turns a payment in 5-unit steps into spaced
// 10/5-unit coin strobes, then waits for the machine's dispense/change reply.
module vend_coin_feeder #(
  parameter int AMT_W   = 6,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  vend_coin_feeder_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, INSERT, GAP, WAIT, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [AMT_W-1:0] steps, steps_nx, coin_src;
  logic             i_q, j_q, done_q, ready_q, disp_q, chg_q, to_q;
  logic             i_nx, j_nx, done_nx, ready_nx, disp_nx, chg_nx, to_nx;
  logic             resp, to_hit;

  assign resp   = bus.X || bus.Y;
  assign to_hit = (cnt >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      steps   <= '0;
      i_q     <= 1'b0;
      j_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      disp_q  <= 1'b0;
      chg_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      steps   <= steps_nx;
      i_q     <= i_nx;
      j_q     <= j_nx;
      done_q  <= done_nx;
      ready_q <= ready_nx;
      disp_q  <= disp_nx;
      chg_q   <= chg_nx;
      to_q    <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = (bus.req_amount == '0) ? DONE : INSERT;
      INSERT:  state_nx = resp ? DONE : GAP;
      GAP: begin
        if (resp)              state_nx = DONE;
        else if (steps != '0)  state_nx = INSERT;
        else                   state_nx = WAIT;
      end
      WAIT:    if (resp || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are registered, so the coin for the upcoming INSERT cycle is
  // chosen from whichever count will be current then: the request on accept,
  // the already-decremented steps when coming from GAP.
  always_comb begin
    steps_nx = steps;
    cnt_nx   = cnt;
    disp_nx  = disp_q;
    chg_nx   = chg_q;
    to_nx    = to_q;
    coin_src = steps;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          steps_nx = bus.req_amount;
          coin_src = bus.req_amount;
          disp_nx  = 1'b0;
          chg_nx   = 1'b0;
          to_nx    = 1'b0;
        end
      end
      INSERT: begin
        steps_nx = steps - (j_q ? AMT_W'(2) : AMT_W'(1));
        disp_nx  = disp_q | bus.X;
        chg_nx   = chg_q | bus.Y;
      end
      GAP: begin
        disp_nx = disp_q | bus.X;
        chg_nx  = chg_q | bus.Y;
        if (state_nx == WAIT) cnt_nx = '0;
      end
      WAIT: begin
        disp_nx = disp_q | bus.X;
        chg_nx  = chg_q | bus.Y;
        cnt_nx  = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + 1'b1;
        if (!resp && to_hit) to_nx = 1'b1;
      end
      default: ;
    endcase
    i_nx     = (state_nx == INSERT) && (coin_src == AMT_W'(1));
    j_nx     = (state_nx == INSERT) && (coin_src >= AMT_W'(2));
    done_nx  = (state_nx == DONE);
    ready_nx = (state_nx == IDLE);
  end

  assign bus.req_ready   = ready_q;
  assign bus.i           = i_q;
  assign bus.j           = j_q;
  assign bus.done        = done_q;
  assign bus.dispensed   = disp_q;
  assign bus.change_seen = chg_q;
  assign bus.timeout_err = to_q;
  assign bus.steps_left  = steps;
endmodule

// File: tb/tb_vend_coin_feeder.sv
// Randomised scoreboard bench for vend_coin_feeder: a transaction-level model
// predicts coin timing and outcome; a negedge monitor checks each done pulse.
module tb_vend_coin_feeder;
  localparam int AMT_W = 6;
  localparam int T     = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vend_coin_feeder_if #(.AMT_W(AMT_W)) bus ();

  vend_coin_feeder #(.AMT_W(AMT_W), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int a;
    int n;
    int ncoins;
    int done_t;
    int acc;
    int steps;
    bit dx;
    bit dy;
    bit to;
  } exp_t;

  typedef struct {
    int t;
    bit isj;
  } coin_t;

  exp_t  exp_q[$];
  coin_t coins[$];
  exp_t  mon_e;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act != req) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      coins.delete();
    end else begin
      if (bus.i || bus.j) begin
        chk("coin_excl", int'(bus.i && bus.j), 0);
        coins.push_back('{cyc, bus.j});
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_lat",    cyc - mon_e.acc, mon_e.done_t);
          chk("dispensed",   int'(bus.dispensed), int'(mon_e.dx));
          chk("change_seen", int'(bus.change_seen), int'(mon_e.dy));
          chk("timeout_err", int'(bus.timeout_err), int'(mon_e.to));
          chk("steps_left",  int'(bus.steps_left), mon_e.steps);
          chk("coin_count",  coins.size(), mon_e.ncoins);
          foreach (coins[k]) begin
            if (k < mon_e.ncoins) begin
              chk("coin_time", coins[k].t - mon_e.acc, 2 * k);
              chk("coin_type", int'(coins[k].isj),
                  (k == mon_e.n - 1 && (mon_e.a % 2) == 1) ? 0 : 1);
            end
          end
        end
        coins.delete();
      end
    end
  end

  // m = edge (counted from the accept edge) at which the machine responds; 0 = never.
  task automatic run_txn(input int a, input int m_in, input int xy);
    exp_t e;
    int   m;
    m = (a == 0) ? 0 : m_in;
    chk("ready_idle", int'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_amount = AMT_W'(a);
    @(posedge clk);
    #1;
    e.a = a;
    e.n = (a + 1) / 2;
    e.dx = 1'b0;
    e.dy = 1'b0;
    e.to = 1'b0;
    if (a == 0) begin
      e.done_t = 0;
      e.ncoins = 0;
    end else if (m > 0) begin
      e.done_t = m;
      e.ncoins = (m <= 2 * e.n) ? (m + 1) / 2 : e.n;
      e.dx = xy[0];
      e.dy = xy[1];
    end else begin
      e.done_t = 2 * e.n + T;
      e.ncoins = e.n;
      e.to = 1'b1;
    end
    e.steps = a - ((2 * e.ncoins < a) ? 2 * e.ncoins : a);
    e.acc = cyc;
    exp_q.push_back(e);
    for (int k = 1; k <= e.done_t + 3; k++) begin
      @(negedge clk);
      if (k <= e.done_t) begin
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_amount = AMT_W'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
      if (k == m) begin
        bus.X = xy[0];
        bus.Y = xy[1];
      end else if (k > e.done_t) begin
        bus.X = 1'($urandom_range(0, 1));
        bus.Y = 1'($urandom_range(0, 1));
      end else begin
        bus.X = 1'b0;
        bus.Y = 1'b0;
      end
    end
    @(negedge clk);
    bus.X = 1'b0;
    bus.Y = 1'b0;
    chk("done_seen",   exp_q.size(), 0);
    chk("hold_disp",   int'(bus.dispensed), int'(e.dx));
    chk("hold_change", int'(bus.change_seen), int'(e.dy));
    chk("hold_to",     int'(bus.timeout_err), int'(e.to));
    chk("hold_steps",  int'(bus.steps_left), e.steps);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, int'(bus.req_ready), 1);
    chk({tag, "_ij"},    int'({bus.i, bus.j}), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_flags"}, int'({bus.dispensed, bus.change_seen, bus.timeout_err}), 0);
    chk({tag, "_steps"}, int'(bus.steps_left), 0);
  endtask

  initial begin
    int a, n;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.X          = 1'b0;
    bus.Y          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    run_txn(3, 6, 1);
    run_txn(4, 5, 3);
    run_txn(6, 2, 1);
    run_txn(2, 0, 1);
    run_txn(0, 0, 1);
    run_txn(1, 1, 2);

    // Abort a 5-step payment one cycle after its second coin.
    chk("ready_pre_abort", int'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_amount = AMT_W'(5);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cleared("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_txn(1, 0, 1);

    repeat (40) begin
      a = $urandom_range(0, 63);
      n = (a + 1) / 2;
      run_txn(a, $urandom_range(0, 2 * n + T), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vend_coin_feeder.md
Name: vend_coin_feeder

Overview:
Customer-side driver for the vending machine's coin interface. It accepts a payment request expressed in 5-unit steps and converts it into one-cycle coin strobes on i (5-unit coin) and j (10-unit coin). It then waits for the machine's dispense (X) and change (Y) responses and reports the outcome. It sits opposite the vending machine and drives its i/j inputs in system benches and in the kiosk top level.

Parameters:
AMT_W, 6, width of req_amount (payment in 5-unit steps; max 63 steps)
TIMEOUT, 8, cycles to wait in WAIT for X before flagging timeout_err (must be >= 1)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  1  payment request present
req_amount  input  AMT_W  payment in 5-unit steps; sampled when req_valid && req_ready
req_ready  output  1  high only in IDLE
i  output  1  5-unit coin strobe to vending machine
j  output  1  10-unit coin strobe to vending machine
X  input  1  dispense indication from vending machine
Y  input  1  change indication from vending machine
done  output  1  one-cycle pulse at end of transaction
dispensed  output  1  X seen during the transaction; held until the next accept
change_seen  output  1  Y seen (alone or with X) during the transaction; held until the next accept
timeout_err  output  1  no X within TIMEOUT cycles of the last coin; held until the next accept
steps_left  output  AMT_W  steps not yet inserted; valid while busy and after done

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; i=j=done=dispensed=change_seen=timeout_err=0; steps_left=0; timeout counter=0. rst has priority over all other inputs and aborts any transaction immediately, with no done pulse.
- All outputs are registered. i and j are never high together.
- IDLE: req_ready=1. On req_valid at a posedge:
  - load steps_left=req_amount;
  - clear dispensed, change_seen and timeout_err;
  - go to INSERT, or to DONE if req_amount==0.
- INSERT (one cycle):
  - if steps_left>=2: j=1 for this cycle, steps_left-=2;
  - else (steps_left==1): i=1 for this cycle, steps_left-=1;
  - next state: GAP.
- GAP (one cycle): i=j=0, spacing coins for the machine.
  - If steps_left!=0: next state INSERT.
  - Else: next state WAIT, timeout counter cleared.
- Coin cadence is therefore one coin every 2 cycles. Example: 5 steps gives j, gap, j, gap, i, gap.
- X or Y seen in INSERT or GAP (early dispense, machine already satisfied):
  - set the matching sticky flag(s);
  - skip all remaining coins and go directly to DONE;
  - steps_left retains the uninserted count;
  - a coin strobe already launched in this cycle still completes.
- WAIT:
  - each cycle: if X, set dispensed; if Y, set change_seen; go to DONE when either is set.
  - The counter increments each cycle with no X/Y. On reaching TIMEOUT, set timeout_err and go to DONE.
  - Y without X still ends the transaction (refund case): dispensed=0, change_seen=1.
- DONE (one cycle): done=1, then IDLE. Sticky flags and steps_left persist until the next accepted request.
- X/Y pulses in IDLE or DONE are ignored and do not alter the flags.
- req_valid while not IDLE is ignored; nothing is queued.
- Timeout counter width is clog2(TIMEOUT+1). The counter saturates and does not wrap.

Test Plan:
- Reset then req_amount=3 (15 units), machine raises X 2 cycles after the final gap → j pulse, gap, i pulse, gap; done pulse with dispensed=1, change_seen=0, timeout_err=0, steps_left=0.
- req_amount=4, X and Y raised together in the same cycle in WAIT → j,gap,j,gap; done with dispensed=1, change_seen=1.
- req_amount=6, X asserted during the GAP after the first j → no further coins; done with dispensed=1, steps_left=4.
- req_amount=2, X never asserted, TIMEOUT=8 → one j, then done exactly 8 cycles after entering WAIT with timeout_err=1, dispensed=0.
- req_amount=0 → no i/j activity; done pulse 1 cycle after accept with all flags 0.
- rst=1 in the cycle after the second coin of a req_amount=5 transaction → next cycle all outputs 0, req_ready=1, no done pulse; a new req_amount=1 then produces a single i pulse.
